// File: rtl/score_keeper.sv
// score_keeper: turns goal levels into saturating scores with a timed serve pause and a win freeze
module score_keeper #(
    parameter int unsigned WIN_SCORE      = 5,
    parameter int unsigned SERVE_DELAY_MS = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_1ms,
    input  logic       goal_p1,
    input  logic       goal_p2,
    input  logic [1:0] gstate,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       serve_hold,
    output logic       goal_pulse,
    output logic       last_scorer
);
    typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;

    localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
    localparam logic [15:0] DELAY = 16'(SERVE_DELAY_MS);

    state_t      state_q, state_d;
    logic [2:0]  sync_q, sync_d, prev_q, prev_d;
    logic [3:0]  p1_q, p1_d, p2_q, p2_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d, last_q, last_d;
    logic        ev1, ev2, tick;

    // Sample the async-ish levels once, keep the previous sample, and derive rising-edge events
    always_comb begin
        sync_d = {clk_1ms, goal_p2, goal_p1};
        prev_d = sync_q;
        ev1    = sync_q[0] & ~prev_q[0];
        ev2    = sync_q[1] & ~prev_q[1];
        tick   = sync_q[2] & ~prev_q[2];
    end

    // Next-state and scoring; gstate overrides are resolved before the per-state behaviour
    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        last_d  = last_q;
        if (gstate == 2'b00) begin
            state_d = IDLE;
            p1_d    = '0;
            p2_d    = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
        end else if (gstate[1] && (state_q == PLAY || state_q == HOLD)) begin
            state_d = OVER;
        end else begin
            case (state_q)
                IDLE: begin
                    p1_d    = '0;
                    p2_d    = '0;
                    state_d = (gstate == 2'b01) ? PLAY : IDLE;
                end
                PLAY: begin
                    if (ev1 && ev2) begin
                        state_d = HOLD;
                        cnt_d   = DELAY;
                    end else if (ev1) begin
                        p1_d    = (p1_q < WIN) ? p1_q + 4'd1 : p1_q;
                        pulse_d = 1'b1;
                        last_d  = 1'b0;
                        state_d = (p1_q + 4'd1 >= WIN) ? OVER : HOLD;
                        cnt_d   = DELAY;
                    end else if (ev2) begin
                        p2_d    = (p2_q < WIN) ? p2_q + 4'd1 : p2_q;
                        pulse_d = 1'b1;
                        last_d  = 1'b1;
                        state_d = (p2_q + 4'd1 >= WIN) ? OVER : HOLD;
                        cnt_d   = DELAY;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cnt_d   = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;
                        state_d = (cnt_q <= 16'd1) ? PLAY : HOLD;
                    end
                end
                OVER: state_d = OVER;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sync_q  <= '0;
            prev_q  <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            last_q  <= last_d;
        end
    end

    assign p1_score    = p1_q;
    assign p2_score    = p2_q;
    assign serve_hold  = (state_q != PLAY);
    assign goal_pulse  = pulse_q;
    assign last_scorer = last_q;
endmodule

// File: doc/score_keeper.md
# score_keeper

Goal-event scorekeeper for the ping-pong game. Converts per-player goal indications from the ball/paddle logic into the `p1_score`/`p2_score` counts that the game-state block consumes. Consumes that block's `gstate` back to clear, run or freeze scoring. Inserts a timed serve pause after each goal, and freezes on a win so no extra point can land in the one-cycle window before `gstate` updates.

## Interface
- `WIN_SCORE`, 5: goal count that ends a game; scores saturate here.
- `SERVE_DELAY_MS`, 1000: number of `clk_1ms` rising edges in the post-goal pause; legal range 1..65535.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `clk_1ms`  in  1  1 kHz tick signal, synchronous to `clk`; only its rising edges are used, detected in the `clk` domain.
- `goal_p1`  in  1  level, high while the ball is in player TWO's goal (point to player ONE).
- `goal_p2`  in  1  level, high while the ball is in player ONE's goal (point to player TWO).
- `gstate`  in  2  game state: 00 begin, 01 playing, 10 P1 won, 11 P2 won.
- `p1_score`  out  4  player ONE score, 0..WIN_SCORE.
- `p2_score`  out  4  player TWO score, 0..WIN_SCORE.
- `serve_hold`  out  1  high = ball logic must hold the ball at centre.
- `goal_pulse`  out  1  one-cycle strobe per accepted goal.
- `last_scorer`  out  1  0 = player ONE, 1 = player TWO; last accepted goal.

## Operation
- Edge detect: `goal_p1`, `goal_p2` and `clk_1ms` are each registered once. An event is `x & ~x_q`. A held-high goal counts once.
- FSM states:
  - IDLE
    - Scores are forced to 0 and `serve_hold`=1.
    - Go to PLAY when `gstate`==01.
  - PLAY
    - `serve_hold`=0.
    - Single goal edge: increment that player's score, pulse `goal_pulse`, update `last_scorer`.
      - If the new score == WIN_SCORE, go to OVER.
      - Otherwise go to HOLD and load the delay counter with SERVE_DELAY_MS.
    - Both goal edges in the same cycle: no score change, no `goal_pulse`, `last_scorer` unchanged; go to HOLD (replay serve).
  - HOLD
    - `serve_hold`=1.
    - Each `clk_1ms` edge decrements the counter.
    - When the counter reaches 0, go to PLAY.
    - Goal edges are ignored.
  - OVER
    - `serve_hold`=1; scores frozen; goal edges ignored.
- Overriding `gstate` rules, checked before the state-local rules above:
  - `gstate`==00 in any state: go to IDLE and clear scores on that edge.
  - `gstate`==10 or 11 while in PLAY/HOLD: go to OVER.
- Scores never exceed WIN_SCORE; no wrap. Delay counter is 16 bits.
- Reset and `gstate`==00 have identical effect on outputs. Reset mid-HOLD abandons the count.

## Timing
- Reset values: `p1_score`=0, `p2_score`=0, `serve_hold`=1, `goal_pulse`=0, `last_scorer`=0, state IDLE, all edge registers 0, counter 0.
- Goal latency: input rises and is sampled at edge n. Score, `goal_pulse` and state change are all visible after edge n+1. `goal_pulse` is high for exactly that one cycle.
- `serve_hold` rises in the same cycle as the score update, so the ball is frozen from that cycle on.
- HOLD length: exactly SERVE_DELAY_MS detected `clk_1ms` edges. `serve_hold` falls on the `clk` edge after the final tick edge is detected.
- Game-state lag: the winning score appears at edge n+1 and `gstate` shows a win at edge n+2. The block is already in OVER at n+1, so goals in that window are ignored.
- IDLE→PLAY: one cycle after `gstate` is sampled as 01.

## Test plan
- Reset low 3 cycles, `gstate`=01 → all outputs at reset values. Release reset → IDLE→PLAY, `serve_hold` falls one cycle after `gstate`=01 is sampled.
- `goal_p1` high for 50 cycles in PLAY → `p1_score` 0→1 once, one `goal_pulse`, `last_scorer`=0, `serve_hold`=1 for SERVE_DELAY_MS (set to 3) `clk_1ms` edges, then 0.
- `goal_p1` and `goal_p2` rise in the same cycle → scores unchanged, no `goal_pulse`, HOLD entered, `last_scorer` unchanged.
- `goal_p2` pulsed during HOLD → `p2_score` unchanged.
- Five P2 goals with `gstate` driven 11 one cycle after the fifth → `p2_score`=5, state OVER. A further `goal_p2` pulse before and after `gstate`=11 changes nothing.
- From OVER with scores 3:5, drive `gstate`=00 → both scores 0 on the next edge. Then `gstate`=01 → play resumes and the next goal gives 1:0.
